bf_bus_host: RTL and testbench

Host-side responder for the BF chip's 12-bit pin bus: the other end of the chip's byte-serial opcode/address/data sequence. It sits in the FPGA test harness, on the same clock as the chip. It tracks the chip's exported IoOp state, captures opcode, address high and address low bytes, and services each access against a synchronous byte memory or input/output byte streams. It returns read data on `bus_in` and acknowledges with `op_done`.

---
 rtl/bf_bus_host_pkg.sv | 35 +++
 rtl/bf_bus_host.sv | 203 ++++++++++++++++++++
 tb/tb_bf_bus_host.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf_bus_host_pkg.sv
// ---------------------------------------------------------------------------
// bf_bus_host_pkg
//   Shared BF definitions used by the host-side bus responder:
//   - io_op_t  : the chip's exported IoOp sequencing state (chip_out[10:8])
//   - bus_op_t : the opcode the chip places on the bus during IoOpcode
//   - bit positions of the fields inside chip_out / chip_in
// ---------------------------------------------------------------------------
package bf_bus_host_pkg;

  typedef enum logic [2:0] {
    IoNone      = 3'd0,
    IoOpcode    = 3'd1,
    IoAddrHi    = 3'd2,
    IoAddrLo    = 3'd3,
    IoReadWrite = 3'd4
  } io_op_t;

  // Encodings 5..7 are undefined and are reported through bad_op.
  typedef enum logic [2:0] {
    BusNone  = 3'd0,
    BusRead  = 3'd1,
    BusWrite = 3'd2,
    BusIn    = 3'd3,
    BusOut   = 3'd4
  } bus_op_t;

  // chip_out field positions
  localparam int CHIP_HALTED_BIT  = 11;
  localparam int CHIP_STATE_MSB   = 10;
  localparam int CHIP_STATE_LSB   = 8;
  // chip_in field positions
  localparam int CHIP_OP_DONE_BIT = 8;
  localparam int CHIP_ENABLE_BIT  = 9;

endpackage

// File: rtl/bf_bus_host.sv
// ---------------------------------------------------------------------------
// bf_bus_host
//   Host-side responder for the BF chip's 12-bit pin bus. Follows the chip's
//   IoOp sequence (opcode, address high, address low, read/write), services
//   the access against a synchronous byte memory or the getchar/putchar byte
//   streams, returns the result on bus_in and acknowledges with op_done.
//
// Ports
//   clock, reset        : shared chip clock, synchronous active-high reset
//   run                 : drives chip enable (chip_in[9]) combinationally
//   chip_out[11:0]      : chip io_out {halted, IoOp state[2:0], bus byte}
//   chip_in[11:0]       : chip io_in  {2'b00, run, op_done, bus_in[7:0]}
//   mem_addr/re/we/wdata: synchronous byte memory, mem_rdata valid the cycle
//                         after mem_re
//   in_valid/in_data/in_ready    : input stream (getchar)
//   out_valid/out_data/out_ready : output stream (putchar)
//   halted              : chip_out[11] passed through
//   bad_op              : sticky flag, set by an unsupported opcode
// ---------------------------------------------------------------------------
module bf_bus_host
  import bf_bus_host_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [11:0] chip_out,
  output logic [11:0] chip_in,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic        bad_op
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MEM_RD   = 3'd1;
  localparam logic [2:0] S_MEM_WAIT = 3'd2;
  localparam logic [2:0] S_IN       = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  io_op_t      w_io_state;
  logic [7:0]  w_bus_byte;
  logic        w_rw_ready;

  logic [2:0]  r_state;
  logic [2:0]  r_op_q;
  logic [15:0] r_addr_q;
  logic        r_synced;
  logic [7:0]  r_data_q;
  logic        r_op_done;
  logic        r_mem_re;
  logic        r_mem_we;
  logic [7:0]  r_mem_wdata;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_bad_op;

  assign w_io_state = io_op_t'(chip_out[CHIP_STATE_MSB:CHIP_STATE_LSB]);
  assign w_bus_byte = chip_out[7:0];
  // A read/write phase is only trusted once IoNone has been seen, so a
  // responder reset in the middle of a transaction cannot act on stale
  // opcode/address captures.
  assign w_rw_ready = (w_io_state == IoReadWrite) && r_synced;

  // Capture registers follow the chip state directly, independent of the
  // FSM. While the chip is frozen the same byte is reloaded, which is harmless.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op_q   <= '0;
      r_addr_q <= '0;
      r_synced <= 1'b0;
    end else begin
      if (w_io_state == IoOpcode) r_op_q         <= chip_out[2:0];
      if (w_io_state == IoAddrHi) r_addr_q[15:8] <= w_bus_byte;
      if (w_io_state == IoAddrLo) r_addr_q[7:0]  <= w_bus_byte;
      if (w_io_state == IoNone)   r_synced       <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data_q    <= '0;
      r_op_done   <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_bad_op    <= 1'b0;
    end else begin
      // Memory strobes are single-cycle pulses by default.
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_rw_ready) begin
            case (bus_op_t'(r_op_q))
              BusRead: begin
                r_mem_re <= 1'b1;
                r_state  <= S_MEM_RD;
              end
              BusWrite: begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_bus_byte;
                r_data_q    <= w_bus_byte;
                r_state     <= S_DONE;
              end
              BusIn: begin
                r_in_ready <= 1'b1;
                r_state    <= S_IN;
              end
              BusOut: begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_bus_byte;
                r_state     <= S_OUT;
              end
              default: begin
                r_bad_op <= 1'b1;
                r_data_q <= '0;
                r_state  <= S_DONE;
              end
            endcase
          end
        end

        // mem_re is high during this state; data returns in S_MEM_WAIT.
        S_MEM_RD: r_state <= S_MEM_WAIT;

        // Paths that already waited a cycle raise op_done on entry to S_DONE;
        // the write/bad-op path gets it from S_DONE one cycle later.
        S_MEM_WAIT: begin
          r_data_q  <= mem_rdata;
          r_op_done <= 1'b1;
          r_state   <= S_DONE;
        end

        S_IN: begin
          if (in_valid && r_in_ready) begin
            r_data_q   <= in_data;
            r_in_ready <= 1'b0;
            r_op_done  <= 1'b1;
            r_state    <= S_DONE;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            r_data_q    <= r_out_data;
            r_out_valid <= 1'b0;
            r_op_done   <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        // Hold the acknowledge for as long as the chip sits in IoReadWrite,
        // which covers a frozen chip; release once it moves on.
        S_DONE: begin
          if (w_io_state != IoReadWrite) begin
            r_op_done <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_op_done <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    chip_in                   = '0;
    chip_in[7:0]              = r_data_q;
    chip_in[CHIP_OP_DONE_BIT] = r_op_done;
    chip_in[CHIP_ENABLE_BIT]  = run;
  end

  assign halted    = chip_out[CHIP_HALTED_BIT];
  assign mem_addr  = r_addr_q;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign bad_op    = r_bad_op;

endmodule

// File: tb/tb_bf_bus_host.sv
// ---------------------------------------------------------------------------
// tb_bf_bus_host
//   Drives bf_bus_host with a behavioural model of the chip's IoOp sequence,
//   a synchronous byte memory, and the two byte streams. Expected results come
//   from a reference memory image and the access timing rules of the bus.
// ---------------------------------------------------------------------------
module tb_bf_bus_host;
  import bf_bus_host_pkg::*;

  localparam int CYCLE_BUDGET = 200;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [11:0] chip_out;
  logic [11:0] chip_in;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        halted;
  logic        bad_op;
  logic        tb_halted;

  always #5 clock = ~clock;

  bf_bus_host dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .chip_out  (chip_out),
    .chip_in   (chip_in),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .halted    (halted),
    .bad_op    (bad_op)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Memory served to the DUT, and the reference image the model updates.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        mem_init_done = 1'b0;

  int          re_total = 0;
  int          we_total = 0;
  int          in_hs_total = 0;
  int          out_hs_total = 0;
  logic [15:0] last_re_addr = '0;
  logic [15:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;
  logic [7:0]  last_out_byte = '0;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(16'(i));
      mem_init_done <= 1'b1;
    end
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      we_total      <= we_total + 1;
      last_wr_addr  <= mem_addr;
      last_wr_data  <= mem_wdata;
    end
    if (mem_re === 1'b1) begin
      mem_rdata    <= mem[mem_addr];
      re_total     <= re_total + 1;
      last_re_addr <= mem_addr;
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) in_hs_total <= in_hs_total + 1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      out_hs_total  <= out_hs_total + 1;
      last_out_byte <= out_data;
    end
  end

  typedef struct packed {
    logic [7:0] got;
    int         done_n;
    int         hs_n;
    int         re_n;
    int         we_n;
    int         re_cnt;
    int         we_cnt;
    int         hs_cnt;
    bit         timeout;
    bit         stream_ok;
    bit         quiet;
    bit         held_ok;
    bit         drop_ok;
    logic [7:0] after_bus;
  } obs_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chip_set(input io_op_t st, input logic [7:0] b);
    chip_out = {tb_halted, st, b};
  endtask

  // One complete chip transaction. Cycle n = 0 is the first IoReadWrite cycle.
  task automatic do_txn(input logic [2:0] op, input logic [15:0] addr,
                        input logic [7:0] wbyte, input int stall,
                        input logic [7:0] in_byte, input int run_stall,
                        output obs_t o);
    int n;
    int re0, we0, hs0;
    o = '0;
    o.done_n = -1; o.hs_n = -1; o.re_n = -1; o.we_n = -1;
    o.stream_ok = 1'b1;
    re0 = re_total; we0 = we_total; hs0 = in_hs_total + out_hs_total;
    chip_set(IoNone, 8'h00);      tick();
    chip_set(IoOpcode, {5'b0, op}); tick();
    chip_set(IoAddrHi, addr[15:8]); tick();
    chip_set(IoAddrLo, addr[7:0]);  tick();
    chip_set(IoReadWrite, wbyte);
    n = 0;
    while (n < CYCLE_BUDGET && o.done_n < 0) begin
      in_data   = in_byte;
      in_valid  = (op == BusIn)  && (o.hs_n < 0) && (n >= stall);
      out_ready = (op == BusOut) && (o.hs_n < 0) && (n >= stall);
      if (op == BusIn && n >= 1 && o.hs_n < 0 && in_ready !== 1'b1) o.stream_ok = 1'b0;
      if (op == BusOut && n >= 1 && o.hs_n < 0 &&
          !(out_valid === 1'b1 && out_data === wbyte)) o.stream_ok = 1'b0;
      if (mem_re === 1'b1 && o.re_n < 0) o.re_n = n;
      if (mem_we === 1'b1 && o.we_n < 0) o.we_n = n;
      if (in_valid && in_ready === 1'b1 && o.hs_n < 0) o.hs_n = n;
      if (out_ready && out_valid === 1'b1 && o.hs_n < 0) o.hs_n = n;
      if (chip_in[CHIP_OP_DONE_BIT] === 1'b1) begin
        o.done_n = n;
        o.got    = chip_in[7:0];
        o.quiet  = (in_ready === 1'b0) && (out_valid === 1'b0);
      end else begin
        tick();
        n++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (o.done_n < 0) begin
      o.timeout = 1'b1;
      chip_set(IoNone, 8'h00);
      tick();
    end else begin
      o.held_ok = 1'b1;
      if (run_stall > 0) begin
        run = 1'b0;
        repeat (run_stall) begin
          tick();
          if (chip_in[CHIP_OP_DONE_BIT] !== 1'b1 || chip_in[7:0] !== o.got ||
              chip_in[CHIP_ENABLE_BIT] !== 1'b0) o.held_ok = 1'b0;
        end
        run = 1'b1;
      end
      // The chip latches bus_in on this cycle's closing edge and moves on.
      tick();
      chip_set(IoNone, 8'h00);
      tick();
      o.drop_ok   = (chip_in[CHIP_OP_DONE_BIT] === 1'b0);
      o.after_bus = chip_in[7:0];
    end
    o.re_cnt = re_total - re0;
    o.we_cnt = we_total - we0;
    o.hs_cnt = in_hs_total + out_hs_total - hs0;
  endtask

  task automatic test_reset();
    int re0, we0;
    reset = 1'b1; run = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tb_halted = 1'b0;
    chip_set(IoReadWrite, 8'hFF);
    repeat (3) tick();
    n_total++;
    if (chip_in !== 12'h200) $display("FAIL reset_chip_in: got %h want %h", chip_in, 12'h200);
    else n_pass++;
    n_total++;
    if ({mem_re, mem_we, mem_addr, mem_wdata} !== 26'h0)
      $display("FAIL reset_mem: got re=%b we=%b addr=%h wdata=%h want all 0", mem_re, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    n_total++;
    if ({in_ready, out_valid, out_data, bad_op} !== 11'h0)
      $display("FAIL reset_stream: got in_ready=%b out_valid=%b out_data=%h bad_op=%b want all 0", in_ready, out_valid, out_data, bad_op);
    else n_pass++;
    tb_halted = 1'b1; chip_set(IoReadWrite, 8'hFF); #1;
    n_total++;
    if (halted !== 1'b1) $display("FAIL halted_pass: got %b want 1", halted); else n_pass++;
    tb_halted = 1'b0; chip_set(IoReadWrite, 8'hFF); run = 1'b0; #1;
    n_total++;
    if (halted !== 1'b0 || chip_in[CHIP_ENABLE_BIT] !== 1'b0)
      $display("FAIL halted_run_low: got halted=%b enable=%b want 0 0", halted, chip_in[CHIP_ENABLE_BIT]);
    else n_pass++;
    run = 1'b1;
    // Leaving reset with the chip already in IoReadWrite must not act.
    re0 = re_total; we0 = we_total;
    reset = 1'b0;
    repeat (5) tick();
    n_total++;
    if (chip_in[CHIP_OP_DONE_BIT] !== 1'b0 || re_total != re0 || we_total != we0 || bad_op !== 1'b0)
      $display("FAIL unsynced_rw: got op_done=%b re=%0d we=%0d bad_op=%b want 0 0 0 0",
               chip_in[CHIP_OP_DONE_BIT], re_total - re0, we_total - we0, bad_op);
    else n_pass++;
  endtask

  task automatic test_write();
    obs_t o;
    do_txn(BusWrite, 16'h1234, 8'hA5, 0, 8'h00, 0, o);
    ref_mem[16'h1234] = 8'hA5;
    n_total++;
    if (o.we_n !== 1 || o.we_cnt !== 1 || o.re_cnt !== 0)
      $display("FAIL write_strobe: got we_n=%0d we_cnt=%0d re_cnt=%0d want 1 1 0", o.we_n, o.we_cnt, o.re_cnt);
    else n_pass++;
    n_total++;
    if (last_wr_addr !== 16'h1234 || last_wr_data !== 8'hA5)
      $display("FAIL write_addr_data: got %h/%h want 1234/a5", last_wr_addr, last_wr_data);
    else n_pass++;
    n_total++;
    if (o.done_n !== 2 || o.got !== 8'hA5)
      $display("FAIL write_done: got done_n=%0d bus_in=%h want 2 a5", o.done_n, o.got);
    else n_pass++;
    n_total++;
    if (!o.drop_ok || o.after_bus !== 8'hA5 || mem[16'h1234] !== 8'hA5)
      $display("FAIL write_after: got drop=%0b bus_in=%h mem=%h want 1 a5 a5", o.drop_ok, o.after_bus, mem[16'h1234]);
    else n_pass++;
  endtask

  task automatic test_read();
    obs_t o;
    do_txn(BusRead, 16'hFFFF, 8'h00, 0, 8'h00, 0, o);
    n_total++;
    if (o.re_n !== 1 || o.re_cnt !== 1 || o.we_cnt !== 0 || last_re_addr !== 16'hFFFF)
      $display("FAIL read_strobe: got re_n=%0d re_cnt=%0d we_cnt=%0d addr=%h want 1 1 0 ffff",
               o.re_n, o.re_cnt, o.we_cnt, last_re_addr);
    else n_pass++;
    n_total++;
    if (o.done_n !== 3 || o.got !== 8'h5A || o.got !== ref_mem[16'hFFFF])
      $display("FAIL read_data: got done_n=%0d bus_in=%h want 3 5a", o.done_n, o.got);
    else n_pass++;
    n_total++;
    if (!o.drop_ok) $display("FAIL read_drop: got op_done still high want low"); else n_pass++;
  endtask

  task automatic test_stream_in();
    obs_t o;
    do_txn(BusIn, 16'h0000, 8'h00, 10, 8'h41, 0, o);
    n_total++;
    if (o.hs_n !== 10 || o.hs_cnt !== 1 || !o.stream_ok)
      $display("FAIL in_handshake: got hs_n=%0d hs_cnt=%0d ready_held=%0b want 10 1 1", o.hs_n, o.hs_cnt, o.stream_ok);
    else n_pass++;
    n_total++;
    if (o.done_n !== 11 || o.got !== 8'h41 || !o.quiet)
      $display("FAIL in_done: got done_n=%0d bus_in=%h ready_dropped=%0b want 11 41 1", o.done_n, o.got, o.quiet);
    else n_pass++;
  endtask

  task automatic test_stream_out();
    obs_t o;
    do_txn(BusOut, 16'h0000, 8'h0A, 5, 8'h00, 0, o);
    n_total++;
    if (o.hs_n !== 5 || o.hs_cnt !== 1 || !o.stream_ok || last_out_byte !== 8'h0A)
      $display("FAIL out_handshake: got hs_n=%0d hs_cnt=%0d held=%0b byte=%h want 5 1 1 0a",
               o.hs_n, o.hs_cnt, o.stream_ok, last_out_byte);
    else n_pass++;
    n_total++;
    if (o.done_n !== 6 || o.got !== 8'h0A || !o.quiet)
      $display("FAIL out_done: got done_n=%0d bus_in=%h valid_dropped=%0b want 6 0a 1", o.done_n, o.got, o.quiet);
    else n_pass++;
  endtask

  task automatic test_run_stall();
    obs_t o;
    do_txn(BusRead, 16'h1234, 8'h00, 0, 8'h00, 6, o);
    n_total++;
    if (!o.held_ok || o.re_cnt !== 1 || o.done_n !== 3 || o.got !== ref_mem[16'h1234])
      $display("FAIL run_stall: got held=%0b re_cnt=%0d done_n=%0d bus_in=%h want 1 1 3 %h",
               o.held_ok, o.re_cnt, o.done_n, o.got, ref_mem[16'h1234]);
    else n_pass++;
    n_total++;
    if (!o.drop_ok) $display("FAIL run_stall_drop: got op_done still high want low"); else n_pass++;
  endtask

  task automatic test_resync();
    obs_t o;
    int we0, re0;
    bit quiet;
    chip_set(IoNone, 8'h00);     tick();
    chip_set(IoOpcode, 8'h02);   tick();
    chip_set(IoAddrHi, 8'h55);   tick();
    chip_set(IoAddrLo, 8'h66);   tick();
    we0 = we_total; re0 = re_total;
    chip_set(IoReadWrite, 8'h77);
    reset = 1'b1; tick(); reset = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      tick();
      if (chip_in[CHIP_OP_DONE_BIT] !== 1'b0 || mem_we !== 1'b0) quiet = 1'b0;
    end
    n_total++;
    if (!quiet || we_total != we0 || re_total != re0 || bad_op !== 1'b0)
      $display("FAIL resync_quiet: got quiet=%0b we=%0d re=%0d bad_op=%b want 1 0 0 0",
               quiet, we_total - we0, re_total - re0, bad_op);
    else n_pass++;
    do_txn(BusWrite, 16'h5566, 8'h3C, 0, 8'h00, 0, o);
    ref_mem[16'h5566] = 8'h3C;
    n_total++;
    if (o.we_cnt !== 1 || o.done_n !== 2 || last_wr_data !== 8'h3C || last_wr_addr !== 16'h5566)
      $display("FAIL resync_next: got we_cnt=%0d done_n=%0d data=%h addr=%h want 1 2 3c 5566",
               o.we_cnt, o.done_n, last_wr_data, last_wr_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t        o;
    logic [2:0]  op;
    logic [15:0] addr;
    logic [7:0]  wbyte, in_byte, exp_got;
    int          stall, run_stall, exp_done, sel;
    for (int i = 0; i < 40; i++) begin
      sel       = int'($urandom_range(0, 3));
      addr      = 16'hA000 + 16'($urandom_range(0, 7));
      wbyte     = 8'($urandom);
      in_byte   = 8'($urandom);
      stall     = int'($urandom_range(0, 6));
      run_stall = int'($urandom_range(0, 3));
      case (sel)
        0:       op = BusRead;
        1:       op = BusWrite;
        2:       op = BusIn;
        default: op = BusOut;
      endcase
      // Reference: what the access must return and when.
      case (sel)
        0:       begin exp_got = ref_mem[addr]; exp_done = 3; end
        1:       begin exp_got = wbyte;         exp_done = 2; end
        2:       begin exp_got = in_byte;       exp_done = ((stall < 1) ? 1 : stall) + 1; end
        default: begin exp_got = wbyte;         exp_done = ((stall < 1) ? 1 : stall) + 1; end
      endcase
      do_txn(op, addr, wbyte, stall, in_byte, run_stall, o);
      if (sel == 1) ref_mem[addr] = wbyte;
      n_total++;
      if (o.timeout || o.got !== exp_got || o.done_n !== exp_done)
        $display("FAIL rand_%0d_result: op=%0d got bus_in=%h done_n=%0d timeout=%0b want %h %0d 0",
                 i, op, o.got, o.done_n, o.timeout, exp_got, exp_done);
      else n_pass++;
      n_total++;
      if (o.re_cnt !== ((sel == 0) ? 1 : 0) || o.we_cnt !== ((sel == 1) ? 1 : 0) ||
          o.hs_cnt !== ((sel >= 2) ? 1 : 0))
        $display("FAIL rand_%0d_effects: op=%0d got re=%0d we=%0d hs=%0d want exactly one matching side effect",
                 i, op, o.re_cnt, o.we_cnt, o.hs_cnt);
      else n_pass++;
      n_total++;
      if (!o.held_ok || !o.drop_ok || o.after_bus !== exp_got)
        $display("FAIL rand_%0d_hold: got held=%0b drop=%0b bus_in_after=%h want 1 1 %h",
                 i, o.held_ok, o.drop_ok, o.after_bus, exp_got);
      else n_pass++;
    end
  endtask

  task automatic test_bad_op();
    obs_t o;
    do_txn(BusWrite, 16'h0100, 8'hC3, 0, 8'h00, 0, o);
    ref_mem[16'h0100] = 8'hC3;
    n_total++;
    if (bad_op !== 1'b0) $display("FAIL bad_op_pre: got %b want 0", bad_op); else n_pass++;
    do_txn(3'd7, 16'h0100, 8'hEE, 0, 8'h00, 0, o);
    n_total++;
    if (bad_op !== 1'b1 || o.got !== 8'h00 || o.done_n !== 2 || !o.drop_ok)
      $display("FAIL bad_op_7: got bad_op=%b bus_in=%h done_n=%0d drop=%0b want 1 00 2 1",
               bad_op, o.got, o.done_n, o.drop_ok);
    else n_pass++;
    n_total++;
    if (o.re_cnt !== 0 || o.we_cnt !== 0 || o.hs_cnt !== 0)
      $display("FAIL bad_op_effects: got re=%0d we=%0d hs=%0d want 0 0 0", o.re_cnt, o.we_cnt, o.hs_cnt);
    else n_pass++;
    do_txn(BusRead, 16'h0100, 8'h00, 0, 8'h00, 0, o);
    n_total++;
    if (bad_op !== 1'b1 || o.got !== 8'hC3)
      $display("FAIL bad_op_sticky: got bad_op=%b bus_in=%h want 1 c3", bad_op, o.got);
    else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
    n_total++;
    if (bad_op !== 1'b0) $display("FAIL bad_op_reset: got %b want 0", bad_op); else n_pass++;
    do_txn(BusNone, 16'h0100, 8'h11, 0, 8'h00, 0, o);
    n_total++;
    if (bad_op !== 1'b1 || o.got !== 8'h00)
      $display("FAIL bad_op_none: got bad_op=%b bus_in=%h want 1 00", bad_op, o.got);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    test_reset();
    test_write();
    test_read();
    test_stream_in();
    test_stream_out();
    test_run_stall();
    test_resync();
    test_random();
    test_bad_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
